alu_seq_ctrl: RTL and testbench

Multi-cycle sequencer that executes MUL, DIVU and REMU by iterating on the shared single-cycle ALU. Shift-add multiplication uses the ALU ADD op (4'b0000); restoring division uses the ALU SUB op (4'b0001). It sits beside the execute stage and drives the ALU operand/control inputs through an ownership mux gated by alu_req_o. Requests are accepted with a start/ready handshake, and results are returned with a valid/ack handshake.

---
 rtl/alu_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle MUL / DIVU / REMU sequencer that borrows the shared single-cycle ALU.
// Latency: MUL 1+k (k = index of top set bit of b, plus 1), DIVU/REMU 1+DATA_WIDTH, zero-operand/reserved cases 1.
// Backpressure: ready_o only in IDLE; valid_o/result_o held in DONE until ack_i, start_i ignored outside IDLE.
module alu_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    input  logic                  ack_i,
    output logic                  alu_req_o,
    output logic [DATA_WIDTH-1:0] alu_op1_o,
    output logic [DATA_WIDTH-1:0] alu_op2_o,
    output logic [3:0]            alu_ctrl_o,
    input  logic [DATA_WIDTH-1:0] alu_out_i
);

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    state_t                state_q;
    logic [1:0]            op_q;
    // acc_q: product accumulator for MUL, partial remainder for DIVU/REMU
    logic [DATA_WIDTH-1:0] acc_q;
    // a_q: shifting multiplicand for MUL, dividend/quotient shift register for DIVU/REMU
    logic [DATA_WIDTH-1:0] a_q;
    // b_q: shifting multiplier for MUL, fixed divisor for DIVU/REMU
    logic [DATA_WIDTH-1:0] b_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  is_mul;
    logic                  last_step;
    logic [DATA_WIDTH-1:0] mul_acc_nxt;
    logic [DATA_WIDTH-1:0] mplier_nxt;
    logic [DATA_WIDTH-1:0] rem_shift;
    logic                  rem_ge;
    logic [DATA_WIDTH-1:0] rem_nxt;
    logic [DATA_WIDTH-1:0] quot_nxt;

    assign is_mul      = (op_q == OP_MUL);
    assign last_step   = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));
    assign mul_acc_nxt = b_q[0] ? alu_out_i : acc_q;
    assign mplier_nxt  = b_q >> 1;
    // Remainder never reaches the top bit before the final step, so dropping acc_q[W-1] is safe
    assign rem_shift   = {acc_q[DATA_WIDTH-2:0], a_q[DATA_WIDTH-1]};
    assign rem_ge      = (rem_shift >= b_q);
    assign rem_nxt     = rem_ge ? alu_out_i : rem_shift;
    assign quot_nxt    = {a_q[DATA_WIDTH-2:0], rem_ge};

    // ALU ownership mux: drive operands only while iterating, zeros otherwise
    always_comb begin
        alu_req_o  = 1'b0;
        alu_op1_o  = '0;
        alu_op2_o  = '0;
        alu_ctrl_o = '0;
        if (state_q == STEP) begin
            alu_req_o = 1'b1;
            if (is_mul) begin
                alu_ctrl_o = ALU_ADD;
                alu_op1_o  = acc_q;
                alu_op2_o  = a_q;
            end else begin
                alu_ctrl_o = ALU_SUB;
                alu_op1_o  = rem_shift;
                alu_op2_o  = b_q;
            end
        end
    end

    // Sequencer FSM: accept, iterate one ALU step per cycle, hold result until ack
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && ready_o) begin
                        op_q    <= op_i;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ready_o <= 1'b0;
                        if (op_i == 2'b11 || b_i == '0) begin
                            // Degenerate cases resolve without touching the ALU
                            state_q <= DONE;
                            valid_o <= 1'b1;
                            case (op_i)
                                OP_DIVU: result_o <= '1;
                                OP_REMU: result_o <= a_i;
                                default: result_o <= '0;
                            endcase
                        end else begin
                            state_q <= STEP;
                        end
                    end
                end
                STEP: begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    if (is_mul) begin
                        acc_q <= mul_acc_nxt;
                        a_q   <= a_q << 1;
                        b_q   <= mplier_nxt;
                        // Stop early once no multiplier bits remain
                        if (mplier_nxt == '0 || last_step) begin
                            state_q  <= DONE;
                            valid_o  <= 1'b1;
                            result_o <= mul_acc_nxt;
                        end
                    end else begin
                        acc_q <= rem_nxt;
                        a_q   <= quot_nxt;
                        if (last_step) begin
                            state_q  <= DONE;
                            valid_o  <= 1'b1;
                            result_o <= (op_q == OP_DIVU) ? quot_nxt : rem_nxt;
                        end
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        state_q <= IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with an arithmetic reference model and a behavioural ALU.
// Latency: each operation is timed from its accept cycle to the first valid_o cycle.
// Backpressure: ack_i is withheld for several cycles while start_i is pulsed.
module tb_alu_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic        ack_i;
    logic        alu_req_o;
    logic [31:0] alu_op1_o;
    logic [31:0] alu_op2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_out_i;

    int checks = 0;
    int errors = 0;

    alu_seq_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .ack_i      (ack_i),
        .alu_req_o  (alu_req_o),
        .alu_op1_o  (alu_op1_o),
        .alu_op2_o  (alu_op2_o),
        .alu_ctrl_o (alu_ctrl_o),
        .alu_out_i  (alu_out_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural shared ALU: 0001 subtracts, 0000 adds
    assign alu_out_i = (alu_ctrl_o == 4'b0001) ? (alu_op1_o - alu_op2_o) : (alu_op1_o + alu_op2_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
        int k;
        if (op == 2'b11 || b == 32'd0) return 1;
        if (op != 2'b00) return 33;
        k = 0;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return 1 + k;
    endfunction

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          lat;
        int          exp_lat;
        int          steps_ok;
        logic [31:0] exp_res;
        logic [3:0]  exp_ctrl;
        exp_res  = ref_result(op, a, b);
        exp_lat  = ref_latency(op, b);
        exp_ctrl = (op == 2'b00) ? 4'b0000 : 4'b0001;
        @(negedge clk_i);
        chk({nm, "_idle_ready"}, 32'(ready_o), 32'd1);
        chk({nm, "_idle_alu_req"}, 32'(alu_req_o), 32'd0);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        lat      = 0;
        steps_ok = 0;
        do begin
            @(negedge clk_i);
            start_i = 1'b0;
            lat++;
            if (valid_o !== 1'b1 && alu_req_o === 1'b1 && alu_ctrl_o === exp_ctrl) steps_ok++;
        end while (valid_o !== 1'b1 && lat < 200);
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_result"}, result_o, exp_res);
        chk({nm, "_alu_steps"}, 32'(steps_ok), 32'(exp_lat - 1));
        for (int i = 0; i < hold; i++) begin
            start_i = 1'b1;
            op_i    = 2'b11;
            @(negedge clk_i);
            chk({nm, "_hold_valid"}, 32'(valid_o), 32'd1);
            chk({nm, "_hold_result"}, result_o, exp_res);
            chk({nm, "_hold_ready"}, 32'(ready_o), 32'd0);
        end
        start_i = 1'b0;
        ack_i   = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        chk({nm, "_ack_valid"}, 32'(valid_o), 32'd0);
        chk({nm, "_ack_ready"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        ack_i   = 1'b0;
        op_i    = 2'b00;
        a_i     = '0;
        b_i     = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_alu_req", 32'(alu_req_o), 32'd0);
        chk("rst_alu_op1", alu_op1_o, 32'd0);
        chk("rst_alu_op2", alu_op2_o, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
        rst_i = 1'b0;

        run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 0);
        run_op("mul_5xfffffffd", 2'b00, 32'd5, 32'hFFFF_FFFD, 0);
        run_op("mul_wrap", 2'b00, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 0);
        run_op("remu_100_7", 2'b10, 32'd100, 32'd7, 0);
        run_op("remu_max_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("divu_by0", 2'b01, 32'd5, 32'd0, 0);
        run_op("remu_by0", 2'b10, 32'd5, 32'd0, 0);
        run_op("mul_by0", 2'b00, 32'd1234, 32'd0, 0);
        run_op("op_rsvd", 2'b11, 32'd77, 32'd3, 0);
        run_op("backpressure", 2'b00, 32'd9, 32'd5, 3);
        run_op("after_bp", 2'b01, 32'd1000, 32'd10, 0);

        // ack while nothing is valid must not disturb IDLE
        @(negedge clk_i);
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i = 1'b0;
        chk("idle_ack_valid", 32'(valid_o), 32'd0);
        chk("idle_ack_ready", 32'(ready_o), 32'd1);

        for (int n = 0; n < 20; n++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 3));
            else rb = $urandom >> $urandom_range(0, 31);
            run_op("rnd", rop, ra, rb, int'($urandom_range(0, 2)));
        end

        // Asynchronous reset in the middle of a division
        begin
            int seen_valid;
            @(negedge clk_i);
            start_i = 1'b1;
            op_i    = 2'b01;
            a_i     = 32'd1000;
            b_i     = 32'd3;
            repeat (10) begin
                @(negedge clk_i);
                start_i = 1'b0;
            end
            chk("mid_div_alu_req", 32'(alu_req_o), 32'd1);
            #2 rst_i = 1'b1;
            #1;
            chk("arst_ready", 32'(ready_o), 32'd1);
            chk("arst_valid", 32'(valid_o), 32'd0);
            chk("arst_result", result_o, 32'd0);
            chk("arst_alu_req", 32'(alu_req_o), 32'd0);
            chk("arst_alu_op1", alu_op1_o, 32'd0);
            chk("arst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
            @(negedge clk_i);
            rst_i = 1'b0;
            seen_valid = 0;
            repeat (40) begin
                @(negedge clk_i);
                if (valid_o !== 1'b0) seen_valid = 1;
            end
            chk("arst_no_valid", 32'(seen_valid), 32'd0);
        end
        run_op("mul_3x3_after_rst", 2'b00, 32'd3, 32'd3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
